bloom_counting_filter: RTL and testbench

Single-clock, partitioned counting Bloom filter with insert, delete and query commands on a valid/ready command stream and a registered result stream. It is the next-generation membership engine behind the string search path. It generalises the fixed bit-per-entry hash LUT to HASHES_CNT independent banks of CNT_W-bit saturating counters, so patterns can be removed as well as added. It also adds a hardware clear sweep and saturating statistics counters.

---
 rtl/bloom_counting_filter.sv | 171 +++++++++++++++++
 tb/tb_bloom_counting_filter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_counting_filter.sv
// Partitioned counting Bloom filter (query/insert/delete) with hardware clear sweep and saturating stats.
// Result registered one cycle after acceptance; a held result or a running sweep deasserts cmd_ready_o.
module bloom_counting_filter #(
  parameter int KEY_W      = 32,
  parameter int HASH_W     = 8,
  parameter int HASHES_CNT = 4,
  parameter int CNT_W      = 4,
  parameter int TAG_W      = 8,
  parameter int STAT_W     = 32
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [KEY_W-1:0]  cmd_key_i,
  input  logic [TAG_W-1:0]  cmd_tag_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              res_hit_o,
  output logic [1:0]        res_op_o,
  output logic [TAG_W-1:0]  res_tag_o,
  output logic              res_sat_o,
  output logic              res_err_o,
  input  logic              clear_stb_i,
  output logic              busy_o,
  input  logic              stat_clean_stb_i,
  output logic [STAT_W-1:0] query_cnt_o,
  output logic [STAT_W-1:0] hit_cnt_o,
  output logic [STAT_W-1:0] err_cnt_o
);
  localparam int DEPTH = 1 << HASH_W;
  localparam logic [1:0] OP_QUERY  = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e              state_q, state_d;
  logic [HASH_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q [HASHES_CNT][DEPTH];
  logic [HASH_W-1:0]   idx   [HASHES_CNT];
  logic [CNT_W-1:0]    cur   [HASHES_CNT];
  logic [CNT_W-1:0]    cnt_d [HASHES_CNT];
  logic [HASHES_CNT-1:0] nz, at_max, wr_en;

  logic accept, hit, is_ins, do_dec, err_d;
  logic res_valid_q, res_hit_q, res_sat_q, res_err_q;
  logic [1:0]        res_op_q;
  logic [TAG_W-1:0]  res_tag_q;
  logic [STAT_W-1:0] query_cnt_q, hit_cnt_q, err_cnt_q;

  function automatic logic [HASH_W-1:0] hash_f(input logic [KEY_W-1:0] key, input int k);
    logic [KEY_W-1:0]  rot;
    logic [HASH_W-1:0] h;
    int r;
    r   = (3 * k) % KEY_W;
    rot = (r == 0) ? key : ((key << r) | (key >> (KEY_W - r)));
    h   = HASH_W'(k);
    for (int c = 0; c < KEY_W / HASH_W; c++) h ^= rot[c*HASH_W +: HASH_W];
    return h;
  endfunction

  function automatic logic [STAT_W-1:0] bump(input logic [STAT_W-1:0] v, input logic inc);
    return (inc && !(&v)) ? v + STAT_W'(1) : v;
  endfunction

  // Reset gates ready combinationally so every output reads 0 while arst_n_i is low.
  assign busy_o      = (state_q == ST_CLEAR);
  assign cmd_ready_o = arst_n_i && !busy_o && (!res_valid_q || res_ready_i);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign hit         = &nz;
  assign is_ins      = (cmd_op_i == OP_INSERT);
  assign do_dec      = (cmd_op_i == OP_DELETE) && (CNT_W > 1) && hit;
  assign err_d       = (cmd_op_i == OP_RSVD) || ((cmd_op_i == OP_DELETE) && (CNT_W == 1));

  for (genvar k = 0; k < HASHES_CNT; k++) begin : g_bank
    assign idx[k]    = hash_f(cmd_key_i, k);
    assign cur[k]    = cnt_q[k][idx[k]];
    assign nz[k]     = |cur[k];
    assign at_max[k] = &cur[k];
    assign cnt_d[k]  = is_ins ? cur[k] + CNT_W'(1) : cur[k] - CNT_W'(1);
    // A counter at max never moves again: saturation is sticky for delete too.
    assign wr_en[k]  = accept && (is_ins || do_dec) && !at_max[k];
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int k = 0; k < HASHES_CNT; k++)
        for (int a = 0; a < DEPTH; a++) cnt_q[k][a] <= '0;
    end else begin
      for (int k = 0; k < HASHES_CNT; k++) begin
        if (state_q == ST_CLEAR) cnt_q[k][addr_q] <= '0;
        else if (wr_en[k])       cnt_q[k][idx[k]] <= cnt_d[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: if (clear_stb_i) begin
        state_d = ST_CLEAR;
        addr_d  = '0;
      end
      ST_CLEAR: begin
        addr_d = addr_q + HASH_W'(1);
        if (&addr_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_op_q    <= '0;
      res_tag_q   <= '0;
      res_sat_q   <= 1'b0;
      res_err_q   <= 1'b0;
    end else if (accept) begin
      res_valid_q <= 1'b1;
      res_hit_q   <= hit && (cmd_op_i != OP_RSVD);
      res_op_q    <= cmd_op_i;
      res_tag_q   <= cmd_tag_i;
      res_sat_q   <= is_ins && (|at_max);
      res_err_q   <= err_d;
    end else if (res_ready_i) begin
      res_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      query_cnt_q <= '0;
      hit_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else if (stat_clean_stb_i) begin
      query_cnt_q <= '0;
      hit_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      query_cnt_q <= bump(query_cnt_q, accept && (cmd_op_i == OP_QUERY));
      hit_cnt_q   <= bump(hit_cnt_q, accept && (cmd_op_i == OP_QUERY) && hit);
      err_cnt_q   <= bump(err_cnt_q, accept && err_d);
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_hit_o   = res_hit_q;
  assign res_op_o    = res_op_q;
  assign res_tag_o   = res_tag_q;
  assign res_sat_o   = res_sat_q;
  assign res_err_o   = res_err_q;
  assign query_cnt_o = query_cnt_q;
  assign hit_cnt_o   = hit_cnt_q;
  assign err_cnt_o   = err_cnt_q;
endmodule

// File: tb/tb_bloom_counting_filter.sv
// Directed bench: u0 counting filter (K=2, CNT_W=2, KEY_W=16), u1 plain-bit filter (CNT_W=1).
module tb_bloom_counting_filter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n, v0, v1, res_rdy, clr, sclean;
  logic [1:0]  op;
  logic [15:0] key;
  logic [7:0]  tag;

  logic        rdy0, rv0, hit0, sat0, err0, busy0;
  logic [1:0]  op0;
  logic [7:0]  tag0;
  logic [31:0] q0, h0, e0;
  logic        rdy1, rv1, hit1, sat1, err1, busy1;
  logic [1:0]  op1;
  logic [7:0]  tag1;
  logic [31:0] q1, h1, e1;

  int checks = 0;
  int failures = 0;
  logic       r_valid, r_hit, r_sat, r_err;
  logic [1:0] r_op;
  logic [7:0] r_tag;

  bloom_counting_filter #(.KEY_W(16), .HASH_W(8), .HASHES_CNT(2), .CNT_W(2), .TAG_W(8), .STAT_W(32)) u0 (
    .clk_i(clk), .arst_n_i(arst_n), .cmd_valid_i(v0), .cmd_ready_o(rdy0), .cmd_op_i(op),
    .cmd_key_i(key), .cmd_tag_i(tag), .res_valid_o(rv0), .res_ready_i(res_rdy), .res_hit_o(hit0),
    .res_op_o(op0), .res_tag_o(tag0), .res_sat_o(sat0), .res_err_o(err0), .clear_stb_i(clr),
    .busy_o(busy0), .stat_clean_stb_i(sclean), .query_cnt_o(q0), .hit_cnt_o(h0), .err_cnt_o(e0));

  bloom_counting_filter #(.KEY_W(16), .HASH_W(8), .HASHES_CNT(2), .CNT_W(1), .TAG_W(8), .STAT_W(32)) u1 (
    .clk_i(clk), .arst_n_i(arst_n), .cmd_valid_i(v1), .cmd_ready_o(rdy1), .cmd_op_i(op),
    .cmd_key_i(key), .cmd_tag_i(tag), .res_valid_o(rv1), .res_ready_i(res_rdy), .res_hit_o(hit1),
    .res_op_o(op1), .res_tag_o(tag1), .res_sat_o(sat1), .res_err_o(err1), .clear_stb_i(clr),
    .busy_o(busy1), .stat_clean_stb_i(sclean), .query_cnt_o(q1), .hit_cnt_o(h1), .err_cnt_o(e1));

  // Called at a negedge; returns at the negedge after acceptance with the result captured.
  task automatic send(input bit which, input logic [1:0] o, input logic [15:0] k, input logic [7:0] t);
    int n;
    op = o; key = k; tag = t;
    if (which) v1 = 1'b1; else v0 = 1'b1;
    n = 0;
    while (!(which ? rdy1 : rdy0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      checks++; failures++;
      $display("FAIL send_timeout ready never rose, op=%0d key=%h", o, k);
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    r_valid = which ? rv1 : rv0;   r_hit = which ? hit1 : hit0;
    r_sat   = which ? sat1 : sat0; r_err = which ? err1 : err0;
    r_op    = which ? op1 : op0;   r_tag = which ? tag1 : tag0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; v0 = 0; v1 = 0; op = 0; key = 0; tag = 0; res_rdy = 1; clr = 0; sclean = 0;
    repeat (3) @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", rdy0); end
    checks++; if ({rv0, busy0, hit0, sat0, err0, op0, tag0} !== 15'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {rv0, busy0, hit0, sat0, err0, op0, tag0}); end
    checks++; if ({q0, h0, e0} !== 96'd0) begin failures++; $display("FAIL reset_stats got=%h exp=0", {q0, h0, e0}); end
    arst_n = 1'b1;
    #1;
    checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", rdy0); end
    @(negedge clk);
  endtask

  task automatic test_hash();
    send(0, 2'd1, 16'h1234, 8'h01);
    checks++; if ({r_valid, r_hit, r_sat, r_err, r_op, r_tag} !== {4'b1000, 2'd1, 8'h01}) begin
      failures++; $display("FAIL hash_insert got=%h exp=%h", {r_valid, r_hit, r_sat, r_err, r_op, r_tag}, {4'b1000, 2'd1, 8'h01}); end
    send(0, 2'd0, 16'h1234, 8'h02);
    checks++; if ({r_valid, r_hit, r_tag} !== {2'b11, 8'h02}) begin
      failures++; $display("FAIL hash_query got=%h exp=%h", {r_valid, r_hit, r_tag}, {2'b11, 8'h02}); end
    checks++; if (q0 !== 32'd1 || h0 !== 32'd1) begin failures++; $display("FAIL hash_stats got q=%0d h=%0d exp 1 1", q0, h0); end
    // 0x2600 folds to the same (0x26, 0x30) index pair as 0x1234.
    send(0, 2'd0, 16'h2600, 8'h03);
    checks++; if (r_hit !== 1'b1) begin failures++; $display("FAIL hash_alias got=%b exp=1", r_hit); end
    send(0, 2'd0, 16'h3400, 8'h04);
    checks++; if (r_hit !== 1'b0) begin failures++; $display("FAIL hash_miss got=%b exp=0", r_hit); end
  endtask

  task automatic test_counting();
    send(0, 2'd1, 16'h1234, 8'h10);
    send(0, 2'd2, 16'h1234, 8'h11);
    checks++; if (r_hit !== 1'b1) begin failures++; $display("FAIL cnt_del1_hit got=%b exp=1", r_hit); end
    send(0, 2'd0, 16'h1234, 8'h12);
    checks++; if (r_hit !== 1'b1) begin failures++; $display("FAIL cnt_q1 got=%b exp=1", r_hit); end
    send(0, 2'd2, 16'h1234, 8'h13);
    send(0, 2'd0, 16'h1234, 8'h14);
    checks++; if (r_hit !== 1'b0) begin failures++; $display("FAIL cnt_q2 got=%b exp=0", r_hit); end
    send(0, 2'd2, 16'h1234, 8'h15);
    checks++; if ({r_hit, r_err} !== 2'b00) begin failures++; $display("FAIL cnt_del3 got=%b exp=00", {r_hit, r_err}); end
    // An underflowed counter would read as max here.
    send(0, 2'd1, 16'h1234, 8'h16);
    checks++; if ({r_hit, r_sat} !== 2'b00) begin failures++; $display("FAIL cnt_no_underflow got=%b exp=00", {r_hit, r_sat}); end
    send(0, 2'd0, 16'h1234, 8'h17);
    checks++; if (r_hit !== 1'b1 || q0 !== 32'd6 || h0 !== 32'd4) begin
      failures++; $display("FAIL cnt_final got hit=%b q=%0d h=%0d exp 1 6 4", r_hit, q0, h0); end
  endtask

  task automatic test_saturation();
    logic s3;
    int bad;
    for (int i = 0; i < 4; i++) begin
      send(0, 2'd1, 16'h00FF, 8'(8'h20 + i));
      if (i == 2) s3 = r_sat;
    end
    checks++; if (s3 !== 1'b0) begin failures++; $display("FAIL sat_third got=%b exp=0", s3); end
    checks++; if ({r_hit, r_sat} !== 2'b11) begin failures++; $display("FAIL sat_fourth got=%b exp=11", {r_hit, r_sat}); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      send(0, 2'd2, 16'h00FF, 8'(8'h30 + i));
      if (r_hit !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL sat_deletes misses=%0d exp=0", bad); end
    send(0, 2'd0, 16'h00FF, 8'h3F);
    checks++; if (r_hit !== 1'b1 || q0 !== 32'd7 || h0 !== 32'd5) begin
      failures++; $display("FAIL sat_sticky got hit=%b q=%0d h=%0d exp 1 7 5", r_hit, q0, h0); end
  endtask

  task automatic test_back_to_back();
    int bad;
    @(negedge clk);
    res_rdy = 1'b0; op = 2'd0; key = 16'h3400; tag = 8'hA0; v0 = 1'b1;
    @(negedge clk);
    tag = 8'hA1;
    checks++; if ({rv0, tag0, rdy0} !== {1'b1, 8'hA0, 1'b0}) begin
      failures++; $display("FAIL bp_first got=%h exp=%h", {rv0, tag0, rdy0}, {1'b1, 8'hA0, 1'b0}); end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (rv0 !== 1'b1 || tag0 !== 8'hA0 || rdy0 !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
    checks++; if (q0 !== 32'd8) begin failures++; $display("FAIL bp_one_accept got=%0d exp=8", q0); end
    res_rdy = 1'b1;
    @(negedge clk);
    checks++; if ({rv0, tag0} !== {1'b1, 8'hA1}) begin failures++; $display("FAIL bp_next got=%h exp=1a1", {rv0, tag0}); end
    tag = 8'hA2;
    @(negedge clk);
    v0 = 1'b0;
    checks++; if ({rv0, tag0} !== {1'b1, 8'hA2}) begin failures++; $display("FAIL bp_next2 got=%h exp=1a2", {rv0, tag0}); end
    @(negedge clk);
    checks++; if (rv0 !== 1'b0 || q0 !== 32'd10 || h0 !== 32'd5) begin
      failures++; $display("FAIL bp_drain got v=%b q=%0d h=%0d exp 0 10 5", rv0, q0, h0); end
  endtask

  task automatic test_errors();
    send(0, 2'd3, 16'h1234, 8'h33);
    checks++; if ({r_hit, r_err, r_op} !== {2'b01, 2'd3}) begin
      failures++; $display("FAIL err_rsvd got=%b exp=0111", {r_hit, r_err, r_op}); end
    checks++; if (e0 !== 32'd1) begin failures++; $display("FAIL err_cnt got=%0d exp=1", e0); end
    sclean = 1'b1;
    send(0, 2'd0, 16'h1234, 8'h34);
    sclean = 1'b0;
    checks++; if ({q0, h0, e0} !== 96'd0) begin failures++; $display("FAIL stat_clean got q=%0d h=%0d e=%0d exp 0", q0, h0, e0); end
    send(1, 2'd1, 16'h1234, 8'h40);
    send(1, 2'd2, 16'h1234, 8'h41);
    checks++; if ({r_hit, r_err} !== 2'b11 || e1 !== 32'd1) begin
      failures++; $display("FAIL plain_delete got hit_err=%b e=%0d exp 11 1", {r_hit, r_err}, e1); end
    send(1, 2'd0, 16'h1234, 8'h42);
    checks++; if (r_hit !== 1'b1 || h1 !== 32'd1) begin
      failures++; $display("FAIL plain_unchanged got hit=%b h=%0d exp 1 1", r_hit, h1); end
  endtask

  task automatic test_clear();
    int busy_cycles, rdy_bad, hold_bad, hits;
    for (int i = 0; i < 10; i++) send(0, 2'd1, 16'(16'h1000 + i * 16'h0123), 8'(i));
    @(negedge clk);
    res_rdy = 1'b0; clr = 1'b1; op = 2'd1; key = 16'h1000; tag = 8'h77; v0 = 1'b1;
    @(negedge clk);
    clr = 1'b0; v0 = 1'b0;
    checks++; if ({rv0, hit0, tag0} !== {2'b11, 8'h77}) begin
      failures++; $display("FAIL clear_same_cycle got=%h exp=377", {rv0, hit0, tag0}); end
    busy_cycles = 0; rdy_bad = 0; hold_bad = 0;
    while (busy0 === 1'b1 && busy_cycles < 600) begin
      busy_cycles++;
      if (rdy0 !== 1'b0) rdy_bad++;
      if (busy_cycles < 20 && (rv0 !== 1'b1 || tag0 !== 8'h77)) hold_bad++;
      if (busy_cycles == 20) res_rdy = 1'b1;
      clr = (busy_cycles == 100);
      @(negedge clk);
    end
    clr = 1'b0;
    checks++; if (busy_cycles != 256) begin failures++; $display("FAIL clear_duration got=%0d exp=256", busy_cycles); end
    checks++; if (rdy_bad != 0) begin failures++; $display("FAIL clear_ready_low bad=%0d exp=0", rdy_bad); end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL clear_pending_hold bad=%0d exp=0", hold_bad); end
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      send(0, 2'd0, 16'(16'h1000 + i * 16'h0123), 8'(8'h80 + i));
      if (r_hit !== 1'b0) hits++;
    end
    send(0, 2'd0, 16'h00FF, 8'h8F);
    if (r_hit !== 1'b0) hits++;
    checks++; if (hits != 0) begin failures++; $display("FAIL clear_contents hits=%0d exp=0", hits); end
  endtask

  task automatic test_reset_mid_sweep();
    send(0, 2'd1, 16'h5555, 8'h51);
    send(0, 2'd0, 16'h5555, 8'h52);
    checks++; if (r_hit !== 1'b1) begin failures++; $display("FAIL rst_pre_hit got=%b exp=1", r_hit); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL rst_mid_busy got=%b exp=1", busy0); end
    arst_n = 1'b0;
    #1;
    checks++; if ({busy0, rdy0, rv0, hit0, sat0, err0, op0, tag0} !== 16'd0) begin
      failures++; $display("FAIL rst_mid_outputs got=%h exp=0", {busy0, rdy0, rv0, hit0, sat0, err0, op0, tag0}); end
    checks++; if ({q0, h0, e0} !== 96'd0) begin failures++; $display("FAIL rst_mid_stats got=%h exp=0", {q0, h0, e0}); end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    send(0, 2'd0, 16'h5555, 8'h53);
    checks++; if ({r_hit, busy0} !== 2'b00) begin failures++; $display("FAIL rst_mid_contents got=%b exp=00", {r_hit, busy0}); end
  endtask

  initial begin
    test_reset();
    test_hash();
    test_counting();
    test_saturation();
    test_back_to_back();
    test_errors();
    test_clear();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
